// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache access responder: opcodes, flit layout
// and the one-hot FSM encoding.
package dcache_pkg;

    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_FILL  = 4'd3;
    localparam logic [3:0] OP_INV   = 4'd4;

    localparam int OPC_HI  = 143;
    localparam int OPC_LO  = 140;
    localparam int ADDR_HI = 139;
    localparam int ADDR_LO = 108;
    localparam int WORD_HI = 107;
    localparam int WORD_LO = 76;
    localparam int LINE_HI = 107;
    localparam int LINE_LO = 44;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_LOOKUP = 5'b00010,
        ST_UPDATE = 5'b00100,
        ST_DONE   = 5'b01000,
        ST_WAIT   = 5'b10000
    } state_e;

    // Line layout is {word1, word0}; sel picks word1 when set.
    function automatic logic [31:0] sel_word(input logic [63:0] line, input logic sel);
        return sel ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/dcache_dm_array.sv
// Direct-mapped tag/valid/data storage with a registered read port and a
// write port carrying per-word enables, tag write and valid set/clear.
module dcache_dm_array #(
    parameter  int SETS  = 64,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 29 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic             rd_valid_o,
    output logic [63:0]      rd_line_o,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [1:0]       wr_word_en_i,
    input  logic [63:0]      wr_line_i,
    input  logic             wr_tag_en_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_vset_i,
    input  logic             wr_vclr_i
);

    logic [TAG_W-1:0] tag_q  [SETS];
    logic [63:0]      data_q [SETS];
    logic [SETS-1:0]  valid_q;

    logic [TAG_W-1:0] rd_tag_q;
    logic             rd_valid_q;
    logic [63:0]      rd_line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_vset_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end else if (wr_vclr_i) begin
            valid_q[wr_idx_i] <= 1'b0;
        end
    end

    // Tag and data are deliberately left unreset; the valid bit guards them.
    always_ff @(posedge clk) begin
        if (wr_tag_en_i)     tag_q[wr_idx_i]         <= wr_tag_i;
        if (wr_word_en_i[0]) data_q[wr_idx_i][31:0]  <= wr_line_i[31:0];
        if (wr_word_en_i[1]) data_q[wr_idx_i][63:32] <= wr_line_i[63:32];
    end

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_tag_q   <= tag_q[rd_idx_i];
            rd_valid_q <= valid_q[rd_idx_i];
            rd_line_q  <= data_q[rd_idx_i];
        end
    end

    assign rd_tag_o   = rd_tag_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_line_o  = rd_line_q;

endmodule

// File: rtl/dcache_access_responder.sv
// Data-cache side of the arbitrated access interface: executes one granted
// LOAD/STORE/FILL/INV flit per 5 cycles and pulses done to release the arbiter.
module dcache_access_responder
    import dcache_pkg::*;
#(
    parameter int SETS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [143:0] flits_dc,
    input  logic         v_flits_dc,
    output logic         dcache_done_access,
    output logic         rsp_valid,
    output logic [31:0]  rsp_data,
    output logic         rsp_hit,
    output logic         rsp_err,
    output logic [3:0]   rsp_op
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 29 - IDX_W;

    state_e       state_q;
    logic [3:0]   op_q;
    logic [31:2]  addr_q;
    logic [63:0]  line_q;

    logic         done_q;
    logic [31:0]  rsp_data_q, rsp_data_d;
    logic         rsp_hit_q, rsp_hit_d;
    logic         rsp_err_q, rsp_err_d;
    logic [3:0]   rsp_op_q;

    logic             sel;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      st_word;

    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic [63:0]      rd_line;
    logic             hit;

    logic             upd_en;
    logic [1:0]       word_en_d;
    logic [63:0]      wr_line_d;
    logic             tag_en_d, vset_d, vclr_d;

    logic unused_flit;
    assign unused_flit = ^{flits_dc[LINE_LO-1:0], flits_dc[ADDR_LO+1:ADDR_LO]};

    assign sel     = addr_q[2];
    assign idx     = addr_q[3+IDX_W-1:3];
    assign tag     = addr_q[31:3+IDX_W];
    assign st_word = line_q[WORD_HI-LINE_LO:WORD_LO-LINE_LO];
    assign hit     = rd_valid && (rd_tag == tag);

    always_comb begin
        word_en_d  = 2'b00;
        wr_line_d  = line_q;
        tag_en_d   = 1'b0;
        vset_d     = 1'b0;
        vclr_d     = 1'b0;
        rsp_data_d = '0;
        rsp_hit_d  = hit;
        rsp_err_d  = 1'b0;
        case (op_q)
            OP_LOAD: begin
                if (hit) rsp_data_d = sel_word(rd_line, sel);
            end
            OP_STORE: begin
                if (hit) word_en_d = sel ? 2'b10 : 2'b01;
                wr_line_d = {st_word, st_word};
            end
            OP_FILL: begin
                word_en_d  = 2'b11;
                tag_en_d   = 1'b1;
                vset_d     = 1'b1;
                rsp_data_d = sel_word(line_q, sel);
            end
            OP_INV: begin
                vclr_d = hit;
            end
            default: begin
                rsp_err_d = 1'b1;
                rsp_hit_d = 1'b0;
            end
        endcase
    end

    // A reset landing in UPDATE must not leave a partial write behind.
    assign upd_en = (state_q == ST_UPDATE) && !rst;

    dcache_dm_array #(.SETS(SETS)) u_array (
        .clk          (clk),
        .rst          (rst),
        .rd_en_i      (state_q == ST_LOOKUP),
        .rd_idx_i     (idx),
        .rd_tag_o     (rd_tag),
        .rd_valid_o   (rd_valid),
        .rd_line_o    (rd_line),
        .wr_idx_i     (idx),
        .wr_word_en_i (word_en_d & {2{upd_en}}),
        .wr_line_i    (wr_line_d),
        .wr_tag_en_i  (tag_en_d & upd_en),
        .wr_tag_i     (tag),
        .wr_vset_i    (vset_d & upd_en),
        .wr_vclr_i    (vclr_d & upd_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_op_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (v_flits_dc) begin
                        op_q    <= flits_dc[OPC_HI:OPC_LO];
                        addr_q  <= flits_dc[ADDR_HI:ADDR_LO+2];
                        line_q  <= flits_dc[LINE_HI:LINE_LO];
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: state_q <= ST_UPDATE;
                ST_UPDATE: begin
                    done_q     <= 1'b1;
                    rsp_data_q <= rsp_data_d;
                    rsp_hit_q  <= rsp_hit_d;
                    rsp_err_q  <= rsp_err_d;
                    rsp_op_q   <= op_q;
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dcache_done_access = done_q;
    assign rsp_valid          = done_q;
    assign rsp_data           = rsp_data_q;
    assign rsp_hit            = rsp_hit_q;
    assign rsp_err            = rsp_err_q;
    assign rsp_op             = rsp_op_q;

endmodule

// File: tb/tb_dcache_access_responder.sv
// Scoreboard bench: the driver queues the expected response for each flit, a
// negedge monitor pops and compares whenever the responder pulses done.
module tb_dcache_access_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [143:0] flits_dc;
    logic         v_flits_dc;
    logic         dcache_done_access;
    logic         rsp_valid;
    logic [31:0]  rsp_data;
    logic         rsp_hit;
    logic         rsp_err;
    logic [3:0]   rsp_op;

    dcache_access_responder #(.SETS(64)) dut (
        .clk                (clk),
        .rst                (rst),
        .flits_dc           (flits_dc),
        .v_flits_dc         (v_flits_dc),
        .dcache_done_access (dcache_done_access),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .rsp_hit            (rsp_hit),
        .rsp_err            (rsp_err),
        .rsp_op             (rsp_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        hit;
        logic        err;
        logic [31:0] data;
        bit          chk_data;
        int          exp_cyc;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (dcache_done_access || rsp_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done at cycle %0d: done=%b valid=%b, none expected",
                         cyc, dcache_done_access, rsp_valid);
            end else begin
                e = sbq.pop_front();
                check({e.name, ".done"},  {31'd0, dcache_done_access}, 32'd1);
                check({e.name, ".valid"}, {31'd0, rsp_valid}, 32'd1);
                check({e.name, ".cycle"}, cyc, e.exp_cyc);
                check({e.name, ".op"},    {28'd0, rsp_op}, {28'd0, e.op});
                check({e.name, ".hit"},   {31'd0, rsp_hit}, {31'd0, e.hit});
                check({e.name, ".err"},   {31'd0, rsp_err}, {31'd0, e.err});
                if (e.chk_data) check({e.name, ".data"}, rsp_data, e.data);
            end
        end
    end

    // b2b: issued on the done cycle of the previous access, keeping v high.
    task automatic send(input string nm, input logic [3:0] op, input logic [31:0] addr,
                        input logic [63:0] line, input logic hit, input logic err,
                        input logic [31:0] data, input bit chkd, input bit b2b);
        exp_t e;
        bit   got;
        if (!b2b) begin
            v_flits_dc = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
        e.name = nm; e.op = op; e.hit = hit; e.err = err; e.data = data;
        e.chk_data = chkd;
        e.exp_cyc  = b2b ? cyc + 5 : cyc + 3;
        sbq.push_back(e);
        flits_dc   = {op, addr, line, 44'h0};
        v_flits_dc = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (dcache_done_access) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s.timeout: no done within 20 cycles, expected one", nm);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, ".done"},  {31'd0, dcache_done_access}, 32'd0);
        check({nm, ".valid"}, {31'd0, rsp_valid}, 32'd0);
        check({nm, ".data"},  rsp_data, 32'd0);
        check({nm, ".hit"},   {31'd0, rsp_hit}, 32'd0);
        check({nm, ".err"},   {31'd0, rsp_err}, 32'd0);
        check({nm, ".op"},    {28'd0, rsp_op}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        v_flits_dc = 1'b0;
        flits_dc   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        //   name          op    addr          line                      hit err data          chk b2b
        send("ld_cold",    4'd1, 32'h0000_0010, 64'h0,                    0, 0, 32'h0,        1, 0);
        send("fill_10",    4'd3, 32'h0000_0010, 64'hDEADBEEF_12345678,    0, 0, 32'h12345678, 1, 0);
        send("ld_14",      4'd1, 32'h0000_0014, 64'h0,                    1, 0, 32'hDEADBEEF, 1, 0);
        send("ld_10",      4'd1, 32'h0000_0010, 64'h0,                    1, 0, 32'h12345678, 1, 0);
        send("st_10",      4'd2, 32'h0000_0010, 64'hCAFEF00D_00000000,    1, 0, 32'h0,        0, 0);
        send("ld_10_st",   4'd1, 32'h0000_0010, 64'h0,                    1, 0, 32'hCAFEF00D, 1, 0);
        send("ld_14_st",   4'd1, 32'h0000_0014, 64'h0,                    1, 0, 32'hDEADBEEF, 1, 0);
        send("ld_210",     4'd1, 32'h0000_0210, 64'h0,                    0, 0, 32'h0,        1, 0);
        send("st_210",     4'd2, 32'h0000_0210, 64'h11111111_00000000,    0, 0, 32'h0,        1, 0);
        send("ld_10_conf", 4'd1, 32'h0000_0010, 64'h0,                    1, 0, 32'hCAFEF00D, 1, 0);
        send("inv_10",     4'd4, 32'h0000_0010, 64'h0,                    1, 0, 32'h0,        1, 0);
        send("ld_10_inv",  4'd1, 32'h0000_0010, 64'h0,                    0, 0, 32'h0,        1, 0);
        send("inv_10_mis", 4'd4, 32'h0000_0010, 64'h0,                    0, 0, 32'h0,        1, 0);
        send("fill_210",   4'd3, 32'h0000_0210, 64'h22222222_33333333,    0, 0, 32'h33333333, 1, 0);
        send("ill_f",      4'hF, 32'h0000_0214, 64'hFFFFFFFF_FFFFFFFF,    0, 1, 32'h0,        1, 0);
        send("ill_0",      4'h0, 32'h0000_0210, 64'hFFFFFFFF_FFFFFFFF,    0, 1, 32'h0,        1, 0);
        send("ld_214",     4'd1, 32'h0000_0214, 64'h0,                    1, 0, 32'h22222222, 1, 0);
        send("ld_210_b",   4'd1, 32'h0000_0210, 64'h0,                    1, 0, 32'h33333333, 1, 0);
        send("fill_40",    4'd3, 32'h0000_0040, 64'hA5A5A5A5_5A5A5A5A,    0, 0, 32'h5A5A5A5A, 1, 0);

        // Store to the filled line, aborted by rst while in UPDATE.
        v_flits_dc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flits_dc   = {4'd2, 32'h0000_0040, 64'hFFFFFFFF_00000000, 44'h0};
        v_flits_dc = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b1;
        v_flits_dc = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;

        send("ld_44_rst",  4'd1, 32'h0000_0044, 64'h0,                    0, 0, 32'h0,        1, 0);
        send("b2b_fill",   4'd3, 32'h0000_0044, 64'h0BADF00D_600DCAFE,    0, 0, 32'h0BADF00D, 1, 1);
        send("b2b_ld_40",  4'd1, 32'h0000_0040, 64'h0,                    1, 0, 32'h600DCAFE, 1, 1);
        send("b2b_ld_214", 4'd1, 32'h0000_0214, 64'h0,                    0, 0, 32'h0,        1, 1);
        send("b2b_ill",    4'h9, 32'h0000_0040, 64'h0,                    0, 1, 32'h0,        1, 1);

        v_flits_dc = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dcache_access_responder.md
Name: dcache_access_responder

Overview:
- Data-cache side of the arbitrated access interface: consumes the single granted stream (flits_dc, v_flits_dc) and answers with a one-cycle dcache_done_access pulse that releases the arbiter.
- Holds a direct-mapped cache: tag, valid and data arrays built from internal registers.
- Executes LOAD, STORE, FILL and INVALIDATE, and returns a word/hit/error response to the local consumer.

Parameters:
- SETS, 64, number of cache lines; power of two, 2..256.
- IDX_W, $clog2(SETS), index width (derived, not overridden).
- TAG_W, 29-IDX_W, tag width = address bits [31:3+IDX_W].

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flits_dc  in  144  granted access flit; stable while v_flits_dc=1
- v_flits_dc  in  1  flit valid; held high until dcache_done_access
- dcache_done_access  out  1  one-cycle pulse: access complete
- rsp_valid  out  1  one-cycle pulse, coincident with dcache_done_access
- rsp_data  out  32  load/read word; held until next capture
- rsp_hit  out  1  tag match with valid=1 at lookup; held
- rsp_err  out  1  illegal opcode; held
- rsp_op  out  4  opcode of the completed access; held

Behaviour:
- Flit fields:
  - [143:140] opcode: 1 = LOAD, 2 = STORE, 3 = FILL, 4 = INV; others illegal.
  - [139:108] addr.
  - [107:76] store word.
  - [107:44] FILL line, with word1 in [107:76] and word0 in [75:44].
  - [43:0] ignored.
- Address split: addr[2] = word select; addr[3+IDX_W-1:3] = index; addr[31:3+IDX_W] = tag; addr[1:0] ignored.
- FSM states and transitions:
  - IDLE: if v_flits_dc=1, capture opcode/addr/payload into a request register, go to LOOKUP.
  - LOOKUP: register tag, valid and line at the index; compute hit. Go to UPDATE.
  - UPDATE: perform the array write (see per-op rules). Go to DONE.
  - DONE: dcache_done_access=1 and rsp_valid=1; response registers are valid. Go to WAIT.
  - WAIT: one idle cycle for the arbiter to deassert v_flits_dc; v_flits_dc is ignored. Go to IDLE.
- Latency:
  - Capture at edge N (IDLE, v=1); done asserted during cycle N+3.
  - Earliest next capture at edge N+5.
  - Throughput: one access per 5 cycles.
- Per-op rules (hit taken from LOOKUP):
  - LOAD hit: rsp_data = selected word. LOAD miss: rsp_data = 0. No array writes.
  - STORE hit: write the store word into the selected word; other word unchanged. STORE miss: no write (no write-allocate); rsp_data = 0.
  - FILL: write both words, tag, valid=1, regardless of hit. rsp_hit reports the pre-fill state. rsp_data = new selected word.
  - INV: if hit, clear valid; tag/data untouched. rsp_data = 0.
  - Illegal opcode: no array writes; rsp_err=1, rsp_hit=0, rsp_data=0. Done still pulses so the arbiter is never stalled.
- Back-to-back accesses to the same index see prior writes, because UPDATE completes before the next LOOKUP.
- Reset:
  - State goes to IDLE; all valid bits clear.
  - dcache_done_access, rsp_valid, rsp_data, rsp_hit, rsp_err and rsp_op reset to 0.
  - Tag and data arrays are not reset.
- rst asserted mid-access (any state): the access is aborted with no done pulse and no array write. The arbiter is reset by the same rst.
- v_flits_dc dropping before done is a protocol violation; the responder completes the captured access anyway.

Decomposition:
- Shared package dcache_pkg holds:
  - opcode constants OP_LOAD/OP_STORE/OP_FILL/OP_INV;
  - flit field bit positions (OPC_HI/LO, ADDR_HI/LO, WORD_HI/LO, LINE_HI/LO);
  - FSM state encodings, one-hot 5-bit.
- One natural sub-module: dcache_dm_array, holding the tag/valid/data register arrays.
  - Interfaces: registered read port; write port with per-word enables, tag write and valid set/clear.
  - Valid bits have synchronous reset.

Test Plan:
- Reset, then LOAD addr 0x0000_0010 -> done at capture+3 cycles, rsp_hit=0, rsp_data=0, rsp_err=0.
- FILL addr 0x0000_0010 with line {0xDEADBEEF, 0x12345678}, then LOAD 0x0000_0014 -> rsp_hit=1, rsp_data=0xDEADBEEF. LOAD 0x0000_0010 -> rsp_data=0x12345678.
- STORE 0x0000_0010 data 0xCAFEF00D after the fill -> hit=1. A following LOAD 0x10 returns 0xCAFEF00D; LOAD 0x14 still returns 0xDEADBEEF.
- Tag conflict with SETS=64: LOAD 0x0000_0210 (same index 2, different tag) -> hit=0. STORE 0x210 -> no change; LOAD 0x10 still hits.
- INV 0x0000_0010 -> rsp_hit=1; next LOAD 0x10 -> hit=0. Opcode 0xF -> rsp_err=1, done pulses, arrays unchanged.
- Assert rst during UPDATE of a STORE to a line that was filled before reset -> no done pulse. After reset the line reads miss (valid cleared), and back-to-back requests with v held high are accepted every 5 cycles.
